// File: rtl/ospfb_capture_ctrl_pkg.sv
// Shared types and constants for the OSPFB capture run controller.
// Status bit positions are named so software headers and RTL stay in step.
package ospfb_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE,
        ERROR
    } cap_state_t;

    localparam int STAT_TIMEOUT       = 0;
    localparam int STAT_EARLY_TLAST   = 1;
    localparam int STAT_MISSING_TLAST = 2;
    localparam int STAT_FFT_OVF       = 3;
    localparam int STAT_TLAST_EVT     = 4;
    localparam int STAT_CFG           = 5;
    localparam int STAT_W             = 6;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ospfb_capture_ctrl_axis_frame_checker.sv
// Beat counter and framing checker for an AXIS stream carrying fixed-length frames.
// Reports frame ends plus early-tlast and missing-tlast violations on the offending beat.
module axis_frame_checker
    import ospfb_capture_ctrl_pkg::*;
#(
    parameter int BPF = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic hs,
    input  logic tlast,
    output logic frame_end,
    output logic early_tlast,
    output logic missing_tlast
);

    localparam int CW = ctr_width(BPF);

    logic [CW-1:0] beat_cnt;
    logic          last_beat;

    assign last_beat     = (beat_cnt == CW'(BPF - 1));
    assign frame_end     = hs & tlast;
    assign early_tlast   = hs & tlast & ~last_beat;
    assign missing_tlast = hs & ~tlast & last_beat;

    // A tlast always realigns the counter, so one bad frame does not poison the next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (hs) begin
            if (tlast || last_beat) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ospfb_capture_ctrl.sv
// Run controller gating whole FFT frames from the OSPFB stream into the capture buffer.
// Outside a capture window the OSPFB is kept drained so it never back-pressures upstream.
module ospfb_capture_ctrl
    import ospfb_capture_ctrl_pkg::*;
#(
    parameter int SAMP_PER_CLK = 2,
    parameter int FFT_LEN      = 64,
    parameter int DATA_W       = 64,
    parameter int TUSER_W      = 16,
    parameter int FRM_W        = 16,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [FRM_W-1:0]   num_frames,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic [TUSER_W-1:0] s_axis_tuser,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic [TUSER_W-1:0] m_axis_tuser,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    input  logic [1:0]         event_fft_overflow,
    input  logic [1:0]         event_tlast_unexpected,
    input  logic [1:0]         event_tlast_missing,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [STAT_W-1:0]  status,
    output logic [FRM_W-1:0]   frames_captured
);

    localparam int BPF = FFT_LEN / SAMP_PER_CLK;
    localparam int TW  = ctr_width(TIMEOUT_CYC);

    cap_state_t        state;
    cap_state_t        nxt_state;
    logic [STAT_W-1:0] nxt_status;
    logic [FRM_W-1:0]  n_target;
    logic [FRM_W-1:0]  nxt_n;
    logic [FRM_W-1:0]  nxt_frames;
    logic [FRM_W-1:0]  frames_inc;
    logic [TW-1:0]     tmo_cnt;
    logic [TW-1:0]     nxt_tmo;
    logic              capturing;
    logic              hs;
    logic              frame_end;
    logic              early_tlast;
    logic              missing_tlast;

    // Data rides through unconditionally; only tvalid and tready are gated by state.
    assign capturing     = (state == CAPTURE);
    assign s_axis_tready = capturing ? m_axis_tready : 1'b1;
    assign m_axis_tvalid = capturing & s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign frames_inc    = frames_captured + 1'b1;

    axis_frame_checker #(
        .BPF (BPF)
    ) u_checker (
        .clk           (clk),
        .rstn          (rstn),
        .hs            (hs),
        .tlast         (s_axis_tlast),
        .frame_end     (frame_end),
        .early_tlast   (early_tlast),
        .missing_tlast (missing_tlast)
    );

    always_comb begin
        nxt_state  = state;
        nxt_status = status;
        nxt_frames = frames_captured;
        nxt_n      = n_target;
        nxt_tmo    = '0;

        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    if (num_frames != '0) begin
                        nxt_status = '0;
                        nxt_frames = '0;
                        nxt_n      = num_frames;
                        nxt_state  = ARMED;
                    end else begin
                        nxt_status[STAT_CFG] = 1'b1;
                        nxt_state            = ERROR;
                    end
                end
            end
            ARMED: begin
                if (frame_end) begin
                    nxt_state = CAPTURE;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    nxt_status[STAT_TIMEOUT] = 1'b1;
                    nxt_state                = ERROR;
                end else begin
                    nxt_tmo = tmo_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                if (early_tlast) begin
                    nxt_status[STAT_EARLY_TLAST] = 1'b1;
                    nxt_state                    = ERROR;
                end else if (missing_tlast) begin
                    nxt_status[STAT_MISSING_TLAST] = 1'b1;
                    nxt_state                      = ERROR;
                end else if (frame_end) begin
                    nxt_frames = frames_inc;
                    if (frames_inc == n_target) begin
                        nxt_state = DONE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase

        // Abort wins over everything but keeps the last run's results visible.
        if (abort) begin
            nxt_state  = IDLE;
            nxt_status = status;
            nxt_frames = frames_captured;
            nxt_n      = n_target;
        end

        if (busy && (|event_fft_overflow)) begin
            nxt_status[STAT_FFT_OVF] = 1'b1;
        end
        if ((|event_tlast_unexpected) || (|event_tlast_missing)) begin
            nxt_status[STAT_TLAST_EVT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            status          <= '0;
            frames_captured <= '0;
            n_target        <= '0;
            tmo_cnt         <= '0;
        end else begin
            state           <= nxt_state;
            busy            <= (nxt_state == ARMED) || (nxt_state == CAPTURE);
            done            <= (nxt_state == DONE);
            err             <= (nxt_state == ERROR);
            status          <= nxt_status;
            frames_captured <= nxt_frames;
            n_target        <= nxt_n;
            tmo_cnt         <= nxt_tmo;
        end
    end

endmodule

// File: tb/tb_ospfb_capture_ctrl.sv
// Directed bench for ospfb_capture_ctrl: 32-beat frames, timeout shortened to 100 cycles.
// A free-running frame source feeds the DUT; a small reference of the run state predicts the gate.
module tb_ospfb_capture_ctrl;

    localparam int BPF = 32;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [15:0] num_frames;
    logic [63:0] s_axis_tdata;
    logic [15:0] s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [15:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [1:0]  ev_ovf;
    logic [1:0]  ev_unexp;
    logic [1:0]  ev_miss;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  status;
    logic [15:0] frames_captured;

    int src_idx = 0;
    int src_seq = 0;
    int early_at = -1;
    int m_st = 0;
    int m_tmo = 0;
    int m_frames = 0;
    int m_n = 0;
    logic [63:0] got[$];
    int got_last = 0;
    int n_cmp = 0;
    int n_bad = 0;

    ospfb_capture_ctrl #(
        .SAMP_PER_CLK (2),
        .FFT_LEN      (64),
        .DATA_W       (64),
        .TUSER_W      (16),
        .FRM_W        (16),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .start                  (start),
        .abort                  (abort),
        .num_frames             (num_frames),
        .s_axis_tdata           (s_axis_tdata),
        .s_axis_tuser           (s_axis_tuser),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tlast           (s_axis_tlast),
        .s_axis_tready          (s_axis_tready),
        .m_axis_tdata           (m_axis_tdata),
        .m_axis_tuser           (m_axis_tuser),
        .m_axis_tvalid          (m_axis_tvalid),
        .m_axis_tlast           (m_axis_tlast),
        .m_axis_tready          (m_axis_tready),
        .event_fft_overflow     (ev_ovf),
        .event_tlast_unexpected (ev_unexp),
        .event_tlast_missing    (ev_miss),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .status                 (status),
        .frames_captured        (frames_captured)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] global timeout");
    end

    // One clock: drive at posedge+1, check the gate at negedge, then advance source and reference.
    task automatic step(input bit v, input bit rdy);
        bit exp_rdy;
        bit exp_mv;
        bit hs;
        bit last;
        s_axis_tvalid = v;
        s_axis_tdata  = {32'hC0DE_0000, 32'(src_seq)};
        s_axis_tuser  = 16'(src_idx);
        s_axis_tlast  = (src_idx == BPF - 1) || (src_idx == early_at);
        m_axis_tready = rdy;
        @(negedge clk);
        exp_rdy = (m_st == 2) ? rdy : 1'b1;
        exp_mv  = (m_st == 2) && v;
        n_cmp++;
        if (s_axis_tready !== exp_rdy) begin
            n_bad++;
            $display("[TB] FAIL s_tready seq=%0d: got %b, want %b", src_seq, s_axis_tready, exp_rdy);
        end
        n_cmp++;
        if (m_axis_tvalid !== exp_mv) begin
            n_bad++;
            $display("[TB] FAIL m_tvalid seq=%0d: got %b, want %b", src_seq, m_axis_tvalid, exp_mv);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            got.push_back(m_axis_tdata);
            if (m_axis_tlast) got_last++;
            n_cmp++;
            if (m_axis_tuser !== 16'(src_idx)) begin
                n_bad++;
                $display("[TB] FAIL m_tuser seq=%0d: got %0d, want %0d", src_seq, m_axis_tuser, src_idx);
            end
        end
        hs   = v && exp_rdy;
        last = s_axis_tlast;
        if (abort) begin
            m_st = 0;
        end else begin
            case (m_st)
                0, 3, 4: if (start) begin
                    if (num_frames != 0) begin
                        m_st = 1; m_tmo = 0; m_frames = 0; m_n = int'(num_frames);
                    end else begin
                        m_st = 4;
                    end
                end
                1: if (hs && last) m_st = 2;
                   else if (m_tmo == TMO - 1) m_st = 4;
                   else m_tmo++;
                2: if (hs) begin
                    if (last && src_idx != BPF - 1) m_st = 4;
                    else if (!last && src_idx == BPF - 1) m_st = 4;
                    else if (last) begin
                        m_frames++;
                        if (m_frames == m_n) m_st = 3;
                    end
                end
                default: m_st = 0;
            endcase
        end
        if (hs) begin
            src_seq++;
            src_idx = (last || src_idx == BPF - 1) ? 0 : src_idx + 1;
        end
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        ev_ovf = 2'b00; ev_unexp = 2'b00; ev_miss = 2'b00;
    endtask

    task automatic run_until_done(input int bound, input bit random_rdy, input string tag);
        int i = 0;
        while (i < bound && done !== 1'b1) begin
            step(1'b1, random_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            i++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s_wait_done: done=%b after %0d cycles, want 1", tag, done, bound);
        end
    endtask

    task automatic wait_capture(input string tag);
        int i = 0;
        while (m_st != 2 && i < 64) begin
            step(1'b1, 1'b1);
            i++;
        end
        n_cmp++;
        if (m_st != 2) begin
            n_bad++;
            $display("[TB] FAIL %s_wait_capture: capture not reached in 64 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; ev_ovf = '0; ev_unexp = '0; ev_miss = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got %b, want 000", {busy, done, err});
        end
        n_cmp++;
        if (status !== 6'd0 || frames_captured !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_status: status=%b frames=%0d, want 0/0", status, frames_captured);
        end
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_gate: m_tvalid=%b s_tready=%b, want 0/1", m_axis_tvalid, s_axis_tready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned_capture();
        int s0, i0, first, bad;
        got.delete(); got_last = 0;
        repeat (10) step(1'b1, 1'b1);
        s0 = src_seq; i0 = src_idx;
        num_frames = 16'd3; start = 1'b1;
        step(1'b1, 1'b1);
        first = s0 + BPF - i0 + ((i0 == BPF - 1) ? BPF : 0);
        run_until_done(200, 1'b0, "aligned");
        n_cmp++;
        if (got.size() != 96 || got_last != 3) begin
            n_bad++;
            $display("[TB] FAIL aligned_count: beats=%0d tlasts=%0d, want 96/3", got.size(), got_last);
        end
        bad = 0;
        foreach (got[k]) if (got[k] !== {32'hC0DE_0000, 32'(first + k)}) bad++;
        n_cmp++;
        if (bad != 0 || got.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL aligned_data: %0d wrong beats, first got %h, want seq %0d", bad,
                     (got.size() > 0) ? got[0] : 64'd0, first);
        end
        n_cmp++;
        if (frames_captured !== 16'd3 || busy !== 1'b0 || status !== 6'd0) begin
            n_bad++;
            $display("[TB] FAIL aligned_end: frames=%0d busy=%b status=%b, want 3/0/0",
                     frames_captured, busy, status);
        end
    endtask

    task automatic test_backpressure();
        int s0, i0, first, bad;
        got.delete(); got_last = 0;
        s0 = src_seq; i0 = src_idx;
        num_frames = 16'd2; start = 1'b1;
        step(1'b1, 1'b1);
        first = s0 + BPF - i0 + ((i0 == BPF - 1) ? BPF : 0);
        repeat (20) step(1'b1, 1'($urandom_range(0, 1)));
        num_frames = 16'd7; start = 1'b1;
        step(1'b1, 1'($urandom_range(0, 1)));
        num_frames = 16'd2;
        run_until_done(400, 1'b1, "bp");
        n_cmp++;
        if (got.size() != 64 || got_last != 2) begin
            n_bad++;
            $display("[TB] FAIL bp_count: beats=%0d tlasts=%0d, want 64/2", got.size(), got_last);
        end
        bad = 0;
        foreach (got[k]) if (got[k] !== {32'hC0DE_0000, 32'(first + k)}) bad++;
        n_cmp++;
        if (bad != 0 || got.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL bp_data: %0d wrong beats, want consecutive from seq %0d", bad, first);
        end
        n_cmp++;
        if (frames_captured !== 16'd2) begin
            n_bad++;
            $display("[TB] FAIL bp_frames: got %0d, want 2", frames_captured);
        end
    endtask

    task automatic test_early_tlast();
        int i = 0;
        got.delete(); got_last = 0;
        num_frames = 16'd1; start = 1'b1;
        step(1'b1, 1'b1);
        wait_capture("early");
        early_at = 20;
        while (src_idx != 20 && i < 40) begin
            step(1'b1, 1'b1);
            i++;
        end
        step(1'b1, 1'b1);
        early_at = -1;
        n_cmp++;
        if (status !== 6'b000010 || err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL early_status: status=%b err=%b busy=%b, want 000010/1/0", status, err, busy);
        end
        n_cmp++;
        if (got.size() != 21 || got_last != 1) begin
            n_bad++;
            $display("[TB] FAIL early_beats: beats=%0d tlasts=%0d, want 21/1", got.size(), got_last);
        end
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL early_gate: m_tvalid=%b after error, want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_timeout();
        num_frames = 16'd1; start = 1'b1;
        step(1'b0, 1'b1);
        repeat (TMO - 1) step(1'b0, 1'b1);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL tmo_before: err=%b busy=%b at cycle 99, want 0/1", err, busy);
        end
        step(1'b0, 1'b1);
        n_cmp++;
        if (err !== 1'b1 || status !== 6'b000001) begin
            n_bad++;
            $display("[TB] FAIL tmo_hit: err=%b status=%b at cycle 100, want 1/000001", err, status);
        end
        num_frames = 16'd1; start = 1'b1;
        step(1'b1, 1'b1);
        n_cmp++;
        if (status !== 6'd0 || busy !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL tmo_rearm: status=%b busy=%b err=%b, want 0/1/0", status, busy, err);
        end
        run_until_done(100, 1'b0, "tmo");
        n_cmp++;
        if (frames_captured !== 16'd1 || status !== 6'd0) begin
            n_bad++;
            $display("[TB] FAIL tmo_rerun: frames=%0d status=%b, want 1/0", frames_captured, status);
        end
    endtask

    task automatic test_event_flags();
        num_frames = 16'd2; start = 1'b1;
        step(1'b1, 1'b1);
        wait_capture("evt");
        repeat (5) step(1'b1, 1'b1);
        ev_ovf = 2'b10;
        step(1'b1, 1'b1);
        n_cmp++;
        if (status !== 6'b001000) begin
            n_bad++;
            $display("[TB] FAIL evt_ovf: status=%b, want 001000", status);
        end
        run_until_done(100, 1'b0, "evt");
        n_cmp++;
        if (frames_captured !== 16'd2 || status !== 6'b001000 || err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL evt_done: frames=%0d status=%b err=%b, want 2/001000/0",
                     frames_captured, status, err);
        end
        ev_miss = 2'b01;
        step(1'b1, 1'b1);
        n_cmp++;
        if (status !== 6'b011000 || done !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL evt_tlast: status=%b done=%b, want 011000/1", status, done);
        end
    endtask

    task automatic test_abort();
        int i = 0;
        num_frames = 16'd3; start = 1'b1;
        step(1'b1, 1'b1);
        wait_capture("abort");
        while (!(m_frames == 1 && src_idx == 10) && i < 80) begin
            step(1'b1, 1'b1);
            i++;
        end
        abort = 1'b1;
        step(1'b1, 1'b1);
        n_cmp++;
        if ({busy, done, err} !== 3'b000 || frames_captured !== 16'd1 || status !== 6'd0) begin
            n_bad++;
            $display("[TB] FAIL abort_state: bde=%b frames=%0d status=%b, want 000/1/0",
                     {busy, done, err}, frames_captured, status);
        end
        m_axis_tready = 1'b0;
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_gate: s_tready=%b m_tvalid=%b, want 1/0", s_axis_tready, m_axis_tvalid);
        end
        num_frames = 16'd2; start = 1'b1; abort = 1'b1;
        step(1'b1, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || frames_captured !== 16'd1) begin
            n_bad++;
            $display("[TB] FAIL abort_prio: busy=%b frames=%0d, want 0/1", busy, frames_captured);
        end
    endtask

    task automatic test_cfg_error();
        num_frames = 16'd0; start = 1'b1;
        step(1'b1, 1'b1);
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || status !== 6'b100000) begin
            n_bad++;
            $display("[TB] FAIL cfg_zero: err=%b busy=%b status=%b, want 1/0/100000", err, busy, status);
        end
        ev_ovf = 2'b11;
        step(1'b1, 1'b1);
        n_cmp++;
        if (status !== 6'b100000) begin
            n_bad++;
            $display("[TB] FAIL ovf_idle: status=%b, want 100000", status);
        end
    endtask

    task automatic test_reset_mid_capture();
        int i = 0;
        num_frames = 16'd2; start = 1'b1;
        step(1'b1, 1'b1);
        wait_capture("rstmid");
        while (m_frames != 1 && i < 40) begin
            step(1'b1, 1'b1);
            i++;
        end
        repeat (3) step(1'b1, 1'b1);
        m_axis_tready = 1'b0;
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b0 || frames_captured !== 16'd1) begin
            n_bad++;
            $display("[TB] FAIL rstmid_pre: s_tready=%b frames=%0d, want 0/1", s_axis_tready, frames_captured);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rstmid_gate: m_tvalid=%b s_tready=%b, want 0/1", m_axis_tvalid, s_axis_tready);
        end
        n_cmp++;
        if ({busy, done, err} !== 3'b000 || frames_captured !== 16'd0 || status !== 6'd0) begin
            n_bad++;
            $display("[TB] FAIL rstmid_regs: bde=%b frames=%0d status=%b, want 000/0/0",
                     {busy, done, err}, frames_captured, status);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        src_idx = 0;
        m_st = 0;
    endtask

    initial begin
        test_reset();
        test_aligned_capture();
        test_backpressure();
        test_early_tlast();
        test_timeout();
        test_event_flags();
        test_abort();
        test_cfg_error();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
